// File: rtl/alu_pkg.sv
// Shared types and op codes for the two-requester ALU arbiter.
package alu_pkg;

  typedef logic [2:0] alu_op_t;
  typedef logic       req_id_t;

  localparam alu_op_t ALU_ADD = 3'b000;
  localparam alu_op_t ALU_SUB = 3'b001;
  localparam alu_op_t ALU_AND = 3'b010;
  localparam alu_op_t ALU_OR  = 3'b011;
  localparam alu_op_t ALU_XOR = 3'b100;
  localparam alu_op_t ALU_SLT = 3'b101;
  localparam alu_op_t ALU_SLL = 3'b110;
  localparam alu_op_t ALU_SRL = 3'b111;

endpackage

// File: rtl/alu_arbiter_if.sv
// Per-requester request/response handshake bundle for alu_arbiter.
interface alu_arbiter_if;
  import alu_pkg::*;

  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  alu_op_t     req_op;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_zero;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_zero
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_zero
  );

endinterface

// File: rtl/alu.sv
// Purely combinational 32-bit ALU; shifts use only b[4:0], arithmetic wraps.
module alu
  import alu_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  alu_op_t     op_i,
  output logic [31:0] result_o,
  output logic        zero_o
);

  always_comb begin
    result_o = '0;
    case (op_i)
      ALU_ADD: result_o = a_i + b_i;
      ALU_SUB: result_o = a_i - b_i;
      ALU_AND: result_o = a_i & b_i;
      ALU_OR:  result_o = a_i | b_i;
      ALU_XOR: result_o = a_i ^ b_i;
      ALU_SLT: result_o = {31'd0, $signed(a_i) < $signed(b_i)};
      ALU_SLL: result_o = a_i << b_i[4:0];
      ALU_SRL: result_o = a_i >> b_i[4:0];
      default: result_o = '0;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between two requesters: issue register S1,
// then a registered per-requester response slot.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter req_id_t RR_INIT = 1'b0
) (
  input logic          clk,
  input logic          reset_n,
  alu_arbiter_if.slave port0_io,
  alu_arbiter_if.slave port1_io
);

  logic [1:0]  req_valid, rsp_ready, busy, ready, acc;
  logic [31:0] req_a [2];
  logic [31:0] req_b [2];
  alu_op_t     req_op [2];

  logic        s1_valid_q, s1_valid_d;
  req_id_t     s1_id_q, s1_id_d;
  logic [31:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  alu_op_t     s1_op_q, s1_op_d;
  req_id_t     prio_q, prio_d;
  logic [1:0]  rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_result_q [2];
  logic [31:0] rsp_result_d [2];
  logic [1:0]  rsp_zero_q, rsp_zero_d;

  logic [31:0] alu_result;
  logic        alu_zero;

  assign req_valid = {port1_io.req_valid, port0_io.req_valid};
  assign rsp_ready = {port1_io.rsp_ready, port0_io.rsp_ready};
  assign req_a[0]  = port0_io.req_a;
  assign req_a[1]  = port1_io.req_a;
  assign req_b[0]  = port0_io.req_b;
  assign req_b[1]  = port1_io.req_b;
  assign req_op[0] = port0_io.req_op;
  assign req_op[1] = port1_io.req_op;

  // A response being consumed this cycle frees its requester; S1 never does.
  assign busy[0] = (s1_valid_q && s1_id_q == 1'b0) || (rsp_valid_q[0] && !rsp_ready[0]);
  assign busy[1] = (s1_valid_q && s1_id_q == 1'b1) || (rsp_valid_q[1] && !rsp_ready[1]);

  assign ready[0] = !busy[0] && (prio_q == 1'b0 || !(req_valid[1] && !busy[1]));
  assign ready[1] = !busy[1] && (prio_q == 1'b1 || !(req_valid[0] && !busy[0]));
  assign acc      = req_valid & ready;

  always_comb begin
    s1_valid_d = |acc;
    s1_id_d    = s1_id_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_op_d    = s1_op_q;
    prio_d     = prio_q;
    if (acc[0]) begin
      s1_id_d = 1'b0;
      s1_a_d  = req_a[0];
      s1_b_d  = req_b[0];
      s1_op_d = req_op[0];
      prio_d  = 1'b1;
    end else if (acc[1]) begin
      s1_id_d = 1'b1;
      s1_a_d  = req_a[1];
      s1_b_d  = req_b[1];
      s1_op_d = req_op[1];
      prio_d  = 1'b0;
    end
  end

  // A completion landing on the same edge as a consume takes the slot.
  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    for (int k = 0; k < 2; k++) begin
      if (s1_valid_q && s1_id_q == k[0]) begin
        rsp_valid_d[k]  = 1'b1;
        rsp_result_d[k] = alu_result;
        rsp_zero_d[k]   = alu_zero;
      end else if (rsp_valid_q[k] && rsp_ready[k]) begin
        rsp_valid_d[k]  = 1'b0;
        rsp_result_d[k] = '0;
        rsp_zero_d[k]   = 1'b0;
      end
    end
  end

  alu u_alu (
    .a_i      (s1_a_q),
    .b_i      (s1_b_q),
    .op_i     (s1_op_q),
    .result_o (alu_result),
    .zero_o   (alu_zero)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q   <= 1'b0;
      s1_id_q      <= 1'b0;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      s1_op_q      <= ALU_ADD;
      prio_q       <= RR_INIT;
      rsp_valid_q  <= '0;
      rsp_result_q <= '{default: '0};
      rsp_zero_q   <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_id_q      <= s1_id_d;
      s1_a_q       <= s1_a_d;
      s1_b_q       <= s1_b_d;
      s1_op_q      <= s1_op_d;
      prio_q       <= prio_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
    end
  end

  assign port0_io.req_ready  = ready[0];
  assign port1_io.req_ready  = ready[1];
  assign port0_io.rsp_valid  = rsp_valid_q[0];
  assign port1_io.rsp_valid  = rsp_valid_q[1];
  assign port0_io.rsp_result = rsp_result_q[0];
  assign port1_io.rsp_result = rsp_result_q[1];
  assign port0_io.rsp_zero   = rsp_zero_q[0];
  assign port1_io.rsp_zero   = rsp_zero_q[1];

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: expectations queued at accept, checked at consume.
`timescale 1ns/1ps
module tb_alu_arbiter;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  alu_arbiter_if p0_if ();
  alu_arbiter_if p1_if ();

  alu_arbiter #(
    .RR_INIT (1'b0)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .port0_io (p0_if.slave),
    .port1_io (p1_if.slave)
  );

  int          n_total = 0;
  int          n_bad = 0;
  logic [32:0] exp0_q[$];
  logic [32:0] exp1_q[$];
  int          grant_log[$];
  logic [1:0]  lat1 = '0;
  logic [1:0]  lat2 = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic logic [32:0] model(input alu_op_t op, input logic [31:0] a, b);
    logic [31:0] r;
    case (op)
      3'd0: r = a + b;
      3'd1: r = a - b;
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd6: r = a << b[4:0];
      default: r = a >> b[4:0];
    endcase
    return {(r == 32'd0), r};
  endfunction

  task automatic mon_port(input int k, input logic rv, rr, sv, sr, input logic [31:0] a, b,
                          input logic [31:0] res, input logic z, input alu_op_t op);
    logic [32:0] e;
    logic        empty;
    if (lat2[k[0]]) check($sformatf("rsp%0d_latency", k), 32'(sv), 32'd1);
    if (lat1[k[0]]) check($sformatf("rsp%0d_early", k), 32'(sv), 32'd0);
    if (sv && sr) begin
      empty = (k == 0) ? (exp0_q.size() == 0) : (exp1_q.size() == 0);
      if (empty) begin
        check($sformatf("rsp%0d_spurious", k), 32'd1, 32'd0);
      end else begin
        if (k == 0) e = exp0_q.pop_front();
        else        e = exp1_q.pop_front();
        check($sformatf("rsp%0d_result", k), res, e[31:0]);
        check($sformatf("rsp%0d_zero", k), 32'(z), 32'(e[32]));
      end
    end
    lat2[k[0]] = lat1[k[0]];
    lat1[k[0]] = rv && rr;
    if (rv && rr) begin
      if (k == 0) exp0_q.push_back(model(op, a, b));
      else        exp1_q.push_back(model(op, a, b));
      grant_log.push_back(k);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (p0_if.req_valid && p0_if.req_ready && p1_if.req_valid && p1_if.req_ready)
        check("double_grant", 32'd1, 32'd0);
      mon_port(0, p0_if.req_valid, p0_if.req_ready, p0_if.rsp_valid, p0_if.rsp_ready,
               p0_if.req_a, p0_if.req_b, p0_if.rsp_result, p0_if.rsp_zero, p0_if.req_op);
      mon_port(1, p1_if.req_valid, p1_if.req_ready, p1_if.rsp_valid, p1_if.rsp_ready,
               p1_if.req_a, p1_if.req_b, p1_if.rsp_result, p1_if.rsp_zero, p1_if.req_op);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic v, input alu_op_t op,
                         input logic [31:0] a, b);
    if (k == 0) begin
      p0_if.req_valid = v; p0_if.req_op = op; p0_if.req_a = a; p0_if.req_b = b;
    end else begin
      p1_if.req_valid = v; p1_if.req_op = op; p1_if.req_a = a; p1_if.req_b = b;
    end
  endtask

  // Returns just after the accepting edge.
  task automatic send(input int k, input alu_op_t op, input logic [31:0] a, b);
    logic got;
    got = 1'b0;
    set_req(k, 1'b1, op, a, b);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((k == 0) ? p0_if.req_ready : p1_if.req_ready) begin
        got = 1'b1;
        break;
      end
    end
    tick();
    set_req(k, 1'b0, op, a, b);
    if (!got) check($sformatf("send%0d_timeout", k), 32'd0, 32'd1);
  endtask

  task automatic expect_rsp(input int k, input logic [31:0] res, input logic z);
    tick();
    if (k == 0) begin
      check("rsp0_valid", 32'(p0_if.rsp_valid), 32'd1);
      check("rsp0_value", p0_if.rsp_result, res);
      check("rsp0_zflag", 32'(p0_if.rsp_zero), 32'(z));
    end else begin
      check("rsp1_valid", 32'(p1_if.rsp_valid), 32'd1);
      check("rsp1_value", p1_if.rsp_result, res);
      check("rsp1_zflag", 32'(p1_if.rsp_zero), 32'(z));
    end
  endtask

  task automatic flush();
    exp0_q.delete();
    exp1_q.delete();
    lat1 = '0;
    lat2 = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    flush();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra;
    set_req(0, 1'b0, ALU_ADD, '0, '0);
    set_req(1, 1'b0, ALU_ADD, '0, '0);
    p0_if.rsp_ready = 1'b1;
    p1_if.rsp_ready = 1'b1;

    #2;
    check("rst_rsp0_valid", 32'(p0_if.rsp_valid), 32'd0);
    check("rst_rsp1_valid", 32'(p1_if.rsp_valid), 32'd0);
    check("rst_req0_ready", 32'(p0_if.req_ready), 32'd1);
    #10 reset_n = 1'b1;
    tick();

    // Single add
    send(0, ALU_ADD, 32'd5, 32'd7);
    check("add_rsp1_idle", 32'(p1_if.rsp_valid), 32'd0);
    expect_rsp(0, 32'd12, 1'b0);
    check("add_rsp1_idle2", 32'(p1_if.rsp_valid), 32'd0);

    // Shifts and logic
    send(0, ALU_SLL, 32'h1, 32'h21);
    expect_rsp(0, 32'h2, 1'b0);
    send(1, ALU_SRL, 32'h8000_0000, 32'd31);
    expect_rsp(1, 32'h1, 1'b0);
    send(0, ALU_XOR, 32'hFFFF_0000, 32'h0F0F_0F0F);
    expect_rsp(0, 32'hF0F0_0F0F, 1'b0);
    send(1, ALU_AND, 32'hA, 32'h5);
    expect_rsp(1, 32'h0, 1'b1);
    tick();

    // Contention from a known priority
    do_reset();
    grant_log.delete();
    set_req(0, 1'b1, ALU_SUB, 32'd3, 32'd3);
    set_req(1, 1'b1, ALU_SLT, 32'hFFFF_FFFF, 32'd1);
    repeat (8) tick();
    set_req(0, 1'b0, ALU_SUB, 32'd3, 32'd3);
    set_req(1, 1'b0, ALU_SLT, 32'hFFFF_FFFF, 32'd1);
    check("cont_grants", 32'(grant_log.size()), 32'd8);
    foreach (grant_log[i]) check($sformatf("cont_grant%0d", i), 32'(grant_log[i]), 32'(i % 2));
    check("cont_rsp0_value", p0_if.rsp_result, 32'd0);
    check("cont_rsp0_zflag", 32'(p0_if.rsp_zero), 32'd1);
    expect_rsp(1, 32'd1, 1'b0);
    tick();

    // Backpressure on requester 1 only
    p1_if.rsp_ready = 1'b0;
    send(1, ALU_SUB, 32'h8000_0000, 32'd1);
    set_req(1, 1'b1, ALU_ADD, 32'd2, 32'd3);
    tick();
    for (int i = 0; i < 3; i++) begin
      check("bp_hold_valid", 32'(p1_if.rsp_valid), 32'd1);
      check("bp_hold_value", p1_if.rsp_result, 32'h7FFF_FFFF);
      check("bp_req1_ready", 32'(p1_if.req_ready), 32'd0);
      send(0, ALU_ADD, 32'(i), 32'd10);
      expect_rsp(0, 32'(i + 10), 1'b0);
    end
    p1_if.rsp_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(p1_if.req_ready), 32'd1);
    tick();
    set_req(1, 1'b0, ALU_ADD, 32'd2, 32'd3);
    expect_rsp(1, 32'd5, 1'b0);
    tick();

    // Consume and accept on the same edge
    p0_if.rsp_ready = 1'b0;
    send(0, ALU_OR, 32'hF0, 32'h0F);
    expect_rsp(0, 32'hFF, 1'b0);
    p0_if.rsp_ready = 1'b1;
    set_req(0, 1'b1, ALU_OR, 32'd1, 32'd2);
    #1;
    check("bypass_ready", 32'(p0_if.req_ready), 32'd1);
    tick();
    set_req(0, 1'b0, ALU_OR, 32'd1, 32'd2);
    check("bypass_consumed", 32'(p0_if.rsp_valid), 32'd0);
    expect_rsp(0, 32'd3, 1'b0);
    tick();
    check("bypass_no_dup", 32'(p0_if.rsp_valid), 32'd0);

    // Reset while S1 and rsp1 are both occupied
    p1_if.rsp_ready = 1'b0;
    send(1, ALU_ADD, 32'd1, 32'd1);
    tick();
    send(0, ALU_ADD, 32'd2, 32'd2);
    reset_n = 1'b0;
    #1;
    flush();
    check("mid_rst_s1", 32'(dut.s1_valid_q), 32'd0);
    check("mid_rst_rsp0_valid", 32'(p0_if.rsp_valid), 32'd0);
    check("mid_rst_rsp1_valid", 32'(p1_if.rsp_valid), 32'd0);
    check("mid_rst_rsp1_value", p1_if.rsp_result, 32'd0);
    check("mid_rst_rsp0_value", p0_if.rsp_result, 32'd0);
    check("mid_rst_req0_ready", 32'(p0_if.req_ready), 32'd1);
    check("mid_rst_req1_ready", 32'(p1_if.req_ready), 32'd1);
    tick();
    reset_n = 1'b1;
    p1_if.rsp_ready = 1'b1;
    #1;
    check("post_rst_req0_ready", 32'(p0_if.req_ready), 32'd1);
    tick();

    // Random traffic with random backpressure
    for (int i = 0; i < 300; i++) begin
      ra = $urandom();
      set_req(0, 1'($urandom_range(0, 1)), alu_op_t'($urandom_range(0, 7)), ra,
              (i % 4 == 0) ? ra : $urandom());
      set_req(1, 1'($urandom_range(0, 1)), alu_op_t'($urandom_range(0, 7)), $urandom(),
              32'($urandom_range(0, 40)));
      p0_if.rsp_ready = ($urandom_range(0, 3) != 0);
      p1_if.rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    set_req(0, 1'b0, ALU_ADD, '0, '0);
    set_req(1, 1'b0, ALU_ADD, '0, '0);
    p0_if.rsp_ready = 1'b1;
    p1_if.rsp_ready = 1'b1;
    repeat (4) tick();
    check("drain0", 32'(exp0_q.size()), 32'd0);
    check("drain1", 32'(exp1_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
